// File: rtl/f3m_cube_root_if.sv
// f3m_cube_root_if: start/done handshake and operand/result bus
// for the GF(3^97) cube-root unit.
interface f3m_cube_root_if #(
  parameter int W = 194
);
  logic         start;
  logic [W-1:0] in;
  logic [W-1:0] out;
  logic         busy;
  logic         done;

  modport master (
    output start, in,
    input  out, busy, done
  );

  modport slave (
    input  start, in,
    output out, busy, done
  );
endinterface

// File: rtl/f3m_cube_root.sv
// f3m_cube_root: GF(3^97) cube root as in^(3^(M-1)) by repeated cubing.
// Define F3M_CUBE_ROOT_UNROLL2_EN for two cubing stages per cycle.
module f3m_cube_root #(
  parameter int           M     = 97,
  parameter int           ITERS = 96,
  parameter logic [195:0] PX    =
    196'h4000000000000000000000000000000000000000001000002
) (
  input  logic           clk,
  input  logic           reset,
  f3m_cube_root_if.slave bus
);

  localparam int K = 12;

`ifdef F3M_CUBE_ROOT_UNROLL2_EN
  localparam logic [6:0] LAST = 7'(ITERS / 2 - 1);
`else
  localparam logic [6:0] LAST = 7'(ITERS - 1);
`endif

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state_q, state_d;

  logic [2*M-1:0] acc;
  logic [2*M-1:0] nxt;
  logic [2*M-1:0] out_q;
  logic [6:0]     cnt;
  logic           done_q;
  logic           load;
  logic           step;
  logic           fin;

  function automatic logic [1:0] f3_add(
    input logic [1:0] a,
    input logic [1:0] b
  );
    logic [2:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  function automatic logic [1:0] f3_neg(input logic [1:0] a);
    return {a[0], a[1]};
  endfunction

  function automatic logic [1:0] f3_mul(
    input logic [1:0] c,
    input logic [1:0] p
  );
    logic [1:0] r;
    r = 2'd0;
    if (p == 2'd1) r = c;
    if (p == 2'd2) r = f3_neg(c);
    return r;
  endfunction

  // Frobenius spreads digit i to degree 3i; fold degrees >= M
  // back down with x^M = -(x^K*p_K + p_0).
  function automatic logic [2*M-1:0] cube(
    input logic [2*M-1:0] a
  );
    logic [1:0]     t [3*M-2];
    logic [1:0]     c;
    logic [2*M-1:0] r;
    for (int i = 0; i < 3*M-2; i++) t[i] = 2'd0;
    for (int i = 0; i < M; i++) t[3*i] = a[2*i +: 2];
    for (int d = 3*M-3; d >= M; d--) begin
      c = t[d];
      t[d-M] = f3_add(t[d-M],
        f3_neg(f3_mul(c, PX[1:0])));
      t[d-M+K] = f3_add(t[d-M+K],
        f3_neg(f3_mul(c, PX[2*K +: 2])));
    end
    r = '0;
    for (int i = 0; i < M; i++) r[2*i +: 2] = t[i];
    return r;
  endfunction

`ifdef F3M_CUBE_ROOT_UNROLL2_EN
  assign nxt = cube(cube(acc));
`else
  assign nxt = cube(acc);
`endif

  assign bus.out  = out_q;
  assign bus.done = done_q;
  assign bus.busy = (state_q == RUN);

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // next state and datapath controls
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    fin     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST) begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // accumulator, counter and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc    <= '0;
      cnt    <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= fin;
      if (load) begin
        acc <= bus.in;
        cnt <= '0;
      end else if (fin) begin
        acc <= nxt;
        cnt <= '0;
      end else if (step) begin
        acc <= nxt;
        cnt <= cnt + 7'd1;
      end
      if (fin) out_q <= nxt;
    end
  end

endmodule

// File: tb/tb_f3m_cube_root.sv
// tb_f3m_cube_root: random and directed checks of the cube-root unit
// against a schoolbook polynomial model of GF(3^97).
module tb_f3m_cube_root;

`ifdef F3M_CUBE_ROOT_UNROLL2_EN
  localparam int LAT = 48;
`else
  localparam int LAT = 96;
`endif
  localparam int NR = 440;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  f3m_cube_root_if bus ();

  f3m_cube_root dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string        tag,
    input logic [193:0] got,
    input logic [193:0] exp
  );
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // product of two field elements: full multiply, then reduce
  // with x^97 = 2x^12 + 1 (from x^97 + x^12 + 2 = 0)
  function automatic logic [193:0] m_mul(
    input logic [193:0] a,
    input logic [193:0] b
  );
    int pa [97];
    int pb [97];
    int t [193];
    logic [193:0] r;
    for (int i = 0; i < 97; i++) begin
      pa[i] = int'(a[2*i +: 2]);
      pb[i] = int'(b[2*i +: 2]);
    end
    for (int k = 0; k < 193; k++) t[k] = 0;
    for (int i = 0; i < 97; i++)
      for (int j = 0; j < 97; j++)
        t[i+j] = (t[i+j] + pa[i] * pb[j]) % 3;
    for (int d = 192; d >= 97; d--) begin
      t[d-97] = (t[d-97] + t[d]) % 3;
      t[d-85] = (t[d-85] + 2 * t[d]) % 3;
      t[d] = 0;
    end
    r = '0;
    for (int i = 0; i < 97; i++) r[2*i +: 2] = 2'(t[i]);
    return r;
  endfunction

  function automatic logic [193:0] m_cube(input logic [193:0] v);
    return m_mul(m_mul(v, v), v);
  endfunction

  function automatic logic [193:0] m_root(input logic [193:0] v);
    logic [193:0] r;
    r = v;
    for (int i = 0; i < 96; i++) r = m_cube(r);
    return r;
  endfunction

  function automatic logic [193:0] rnd();
    logic [193:0] r;
    r = '0;
    for (int i = 0; i < 97; i++) r[2*i +: 2] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  task automatic start_op(input logic [193:0] v);
    bus.in    = v;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 2 * LAT + 10; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  logic [193:0] dir_in  [5];
  logic [193:0] dir_exp [5];
  logic [193:0] v;
  logic [193:0] v2;
  int lat;
  int nd;
  int dlat;

  initial begin
    dir_in[0] = 194'h1;  dir_exp[0] = 194'h1;
    dir_in[1] = 194'h40; dir_exp[1] = 194'h4;
    dir_in[2] = 194'h80; dir_exp[2] = 194'h8;
    dir_in[3] = 194'h0;  dir_exp[3] = 194'h0;
    dir_in[4] = 194'h2;  dir_exp[4] = 194'h2;

    reset     = 1'b1;
    bus.start = 1'b0;
    bus.in    = '0;
    #12;
    check("rst_out", bus.out, '0);
    check("rst_busy", 194'(bus.busy), 194'd0);
    check("rst_done", 194'(bus.done), 194'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int n = 0; n < 5; n++) begin
      start_op(dir_in[n]);
      check("dir_busy_run", 194'(bus.busy), 194'd1);
      wait_done(lat);
      check("dir_lat", 194'(lat), 194'(LAT));
      check("dir_out", bus.out, dir_exp[n]);
      check("dir_busy_done", 194'(bus.busy), 194'd0);
      @(posedge clk);
      #1;
      check("dir_pulse", 194'(bus.done), 194'd0);
      check("dir_hold", bus.out, dir_exp[n]);
    end

    for (int n = 0; n < NR; n++) begin
      v = rnd();
      start_op(v);
      wait_done(lat);
      check("rnd_lat", 194'(lat), 194'(LAT));
      check("rnd_cube", m_cube(bus.out), v);
      if (n < 4) check("rnd_model", bus.out, m_root(v));
    end

    v = rnd();
    start_op(v);
    nd   = 0;
    dlat = -1;
    for (int k = 1; k <= LAT; k++) begin
      bus.in    = rnd();
      bus.start = (k == 10 || k == LAT - 46);
      @(posedge clk);
      #1;
      if (bus.done) begin
        nd++;
        dlat = k;
      end
    end
    bus.start = 1'b0;
    check("ign_ndone", 194'(nd), 194'd1);
    check("ign_lat", 194'(dlat), 194'(LAT));
    check("ign_out", bus.out, m_root(v));
    v2 = rnd();
    start_op(v2);
    wait_done(lat);
    check("b2b_lat", 194'(lat), 194'(LAT));
    check("b2b_cube", m_cube(bus.out), v2);

    start_op({194{1'b1}});
    wait_done(lat);
    check("bad_enc_lat", 194'(lat), 194'(LAT));
    @(posedge clk);
    #1;

    v = rnd();
    start_op(v);
    repeat (39) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out", bus.out, '0);
    check("arst_busy", 194'(bus.busy), 194'd0);
    check("arst_done", 194'(bus.done), 194'd0);
    #2;
    reset = 1'b0;
    nd = 0;
    repeat (LAT + 5) begin
      @(posedge clk);
      #1;
      if (bus.done) nd++;
    end
    check("arst_nodone", 194'(nd), 194'd0);
    check("arst_out_hold", bus.out, '0);
    v = rnd();
    start_op(v);
    wait_done(lat);
    check("post_rst_lat", 194'(lat), 194'(LAT));
    check("post_rst_cube", m_cube(bus.out), v);

    $display("Simulation finished: %0d checks, %0d errors",
      checks, errors);
    $finish;
  end

endmodule
